// File: rtl/onn_pkg.sv
// onn_pkg: shared types and constants for the coupled ONN neuron.
package onn_pkg;
   localparam int PHASE_W_DEF  = 16;
   localparam int WEIGHT_W_DEF = 4;
   typedef logic [PHASE_W_DEF-1:0] phase_t;
   typedef logic signed [WEIGHT_W_DEF-1:0] weight_t;
   localparam phase_t PHASE_HALF = phase_t'(1) << (PHASE_W_DEF - 1);
   typedef enum logic [1:0] {IDLE, ACCUM, APPLY} state_t;
endpackage

// File: rtl/onn_coupled_neuron_if.sv
// onn_coupled_neuron_if: control, neighbour and phase-result signals of one ONN node.
interface onn_coupled_neuron_if #(
   parameter int N_IN     = 4,
   parameter int PHASE_W  = onn_pkg::PHASE_W_DEF,
   parameter int WEIGHT_W = onn_pkg::WEIGHT_W_DEF
);
   logic                     i_tick_en;
   logic                     i_couple_en;
   logic                     i_phi_load;
   logic [PHASE_W-1:0]       i_phi_init;
   logic [N_IN-1:0]          i_nin;
   logic [N_IN*WEIGHT_W-1:0] i_weights;
   logic                     o_nout;
   logic [PHASE_W-1:0]       o_phi_out;
   logic                     o_phi_valid;
   logic                     i_phi_ready;
   logic                     o_upd_busy;
   modport slave (
      input  i_tick_en, i_couple_en, i_phi_load, i_phi_init, i_nin, i_weights, i_phi_ready,
      output o_nout, o_phi_out, o_phi_valid, o_upd_busy
   );
   modport master (
      output i_tick_en, i_couple_en, i_phi_load, i_phi_init, i_nin, i_weights, i_phi_ready,
      input  o_nout, o_phi_out, o_phi_valid, o_upd_busy
   );
endinterface

// File: rtl/onn_phase_capture.sv
// onn_phase_capture: synchronises one neighbour wave and latches its phase offset
// at the first rising edge of each own period.
module onn_phase_capture import onn_pkg::*; #(
   parameter int                 PHASE_W = PHASE_W_DEF,
   parameter logic [PHASE_W-1:0] HALF    = PHASE_W'(PHASE_HALF)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_nin,
   input  logic                      i_bnd,
   input  logic [PHASE_W-1:0]        i_p,
   output logic signed [PHASE_W-1:0] o_d,
   output logic                      o_vld
);
   logic [1:0]                r_sync;
   logic                      r_prev;
   logic                      r_vld;
   logic signed [PHASE_W-1:0] r_d;
   logic                      w_edge;
   assign w_edge = r_sync[1] & ~r_prev;
   assign o_d    = r_d;
   assign o_vld  = r_vld;
   // an edge on the boundary cycle opens the new period, so it beats the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_d    <= '0;
         r_vld  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_nin};
         r_prev <= r_sync[1];
         if (w_edge && (!r_vld || i_bnd)) begin
            r_d   <= i_p - HALF;
            r_vld <= 1'b1;
         end else if (i_bnd) begin
            r_vld <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/onn_coupled_neuron.sv
// onn_coupled_neuron: phase oscillator nudged once per period by a weighted sum of
// neighbour phase offsets; define ONN_STEP_SAT_EN to clamp each correction to +/-MAX_STEP.
module onn_coupled_neuron import onn_pkg::*; #(
   parameter int N_IN     = 4,
   parameter int PHASE_W  = PHASE_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int SHIFT    = 4
`ifdef ONN_STEP_SAT_EN
   ,parameter int MAX_STEP = 2 ** (PHASE_W - 4)
`endif
) (
   input logic                clk,
   input logic                reset,
   onn_coupled_neuron_if.slave bus
);
   localparam int SW = PHASE_W + WEIGHT_W + $clog2(N_IN);
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};
   logic [PHASE_W-1:0]        r_acc, r_phi, r_phi_out, w_p, w_corr, w_phi_nxt;
   logic                      r_nout, r_valid, w_bnd, w_start, w_apply;
   state_t                    r_state, w_state_nxt;
   logic [IW-1:0]             r_idx;
   logic signed [SW-1:0]      r_sum, w_prod, w_corr_full;
   logic signed [WEIGHT_W-1:0] w_wsel;
   logic signed [PHASE_W-1:0] w_dsel;
   logic signed [PHASE_W-1:0] w_d [N_IN];
   logic signed [PHASE_W-1:0] r_dsnap [N_IN];
   logic [N_IN-1:0]           w_vld, r_vsnap;
   assign w_p   = r_acc + r_phi;
   assign w_bnd = bus.i_tick_en && (r_acc == '1);
   for (genvar i = 0; i < N_IN; i++) begin : g_cap
      onn_phase_capture #(.PHASE_W(PHASE_W), .HALF(HALF)) u_cap (
         .clk   (clk),
         .reset (reset),
         .i_nin (bus.i_nin[i]),
         .i_bnd (w_bnd),
         .i_p   (w_p),
         .o_d   (w_d[i]),
         .o_vld (w_vld[i])
      );
   end
   assign w_wsel      = bus.i_weights[r_idx*WEIGHT_W +: WEIGHT_W];
   assign w_dsel      = r_dsnap[r_idx];
   assign w_prod      = r_vsnap[r_idx] ? SW'(w_wsel) * SW'(w_dsel) : '0;
   assign w_corr_full = r_sum >>> SHIFT;
`ifdef ONN_STEP_SAT_EN
   localparam logic signed [SW-1:0] MAXS = SW'(MAX_STEP);
   assign w_corr = PHASE_W'(w_corr_full > MAXS ? MAXS : (w_corr_full < -MAXS ? -MAXS : w_corr_full));
`else
   assign w_corr = PHASE_W'(w_corr_full);
`endif
   assign w_phi_nxt       = r_phi - w_corr;
   assign bus.o_nout      = r_nout;
   assign bus.o_phi_out   = r_phi_out;
   assign bus.o_phi_valid = r_valid;
   assign bus.o_upd_busy  = (r_state != IDLE);
   // a load aborts any update in flight; boundaries seen while busy are dropped
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_apply     = 1'b0;
      if (bus.i_phi_load) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_start     = w_bnd & bus.i_couple_en;
               w_state_nxt = w_start ? ACCUM : IDLE;
            end
            ACCUM: w_state_nxt = (r_idx == IW'(N_IN - 1)) ? APPLY : ACCUM;
            default: begin
               w_apply     = 1'b1;
               w_state_nxt = IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc     <= '0;
         r_phi     <= '0;
         r_phi_out <= '0;
         r_nout    <= 1'b0;
         r_valid   <= 1'b0;
         r_idx     <= '0;
         r_sum     <= '0;
         r_vsnap   <= '0;
         r_dsnap   <= '{default: '0};
      end else begin
         if (bus.i_tick_en) r_acc <= r_acc + PHASE_W'(1);
         r_nout <= w_p[PHASE_W-1];
         if (bus.i_phi_load) r_phi <= bus.i_phi_init;
         else if (w_apply)   r_phi <= w_phi_nxt;
         if (w_apply) r_phi_out <= w_phi_nxt;
         r_valid <= w_apply | (r_valid & ~bus.i_phi_ready);
         if (w_start) begin
            r_idx   <= '0;
            r_sum   <= '0;
            r_vsnap <= w_vld;
            r_dsnap <= w_d;
         end else if (r_state == ACCUM) begin
            r_idx <= r_idx + IW'(1);
            r_sum <= r_sum + w_prod;
         end
      end
   end
endmodule

// File: doc/onn_coupled_neuron.md
Name: onn_coupled_neuron

Overview:
Parametrised successor to the single-input ONN neuron. One phase-controlled oscillator is coupled to N_IN neighbour oscillators. Each neighbour's phase offset is measured once per own oscillation period. The block forms a signed weighted sum of those offsets and updates its own phase register at each period boundary. It sits as one node of the ONN array and runs entirely on a single clock, using a tick strobe instead of a second slow clock.

Parameters:
N_IN, 4, number of neighbour oscillator inputs
PHASE_W, 16, phase/oscillator accumulator width; one period = 2^PHASE_W ticks
WEIGHT_W, 4, signed coupling weight width (two's complement)
SHIFT, 4, arithmetic right shift applied to the weighted sum (coupling gain)
MAX_STEP, 2^(PHASE_W-4), correction clamp magnitude (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick_en  in  1  oscillator advance strobe, one tick per asserted cycle
couple_en  in  1  enables phase update at period boundary
phi_load  in  1  load phi_init into phase register
phi_init  in  PHASE_W  initial/forced phase
nin  in  N_IN  neighbour oscillator square waves (asynchronous)
weights  in  N_IN*WEIGHT_W  signed weights; w_j = weights[j*WEIGHT_W +: WEIGHT_W]
nout  out  1  own oscillator output
phi_out  out  PHASE_W  last applied phase
phi_valid  out  1  phi_out valid, held until phi_ready
phi_ready  in  1  consumer accepts phi_out
upd_busy  out  1  update FSM not IDLE

Behaviour:
- Reset (reset=0): acc=0, phi_reg=0, phi_out=0, phi_valid=0, FSM=IDLE, all captures invalid. nout=0 during reset.
- Oscillator: acc increments by 1 on each cycle with tick_en=1 and wraps mod 2^PHASE_W. p = acc + phi_reg (mod). nout = p[MSB], registered.
- Boundary: tick_en=1 while acc = all-ones. This is the wrap.
- Per-input capture, j = 0..N_IN-1:
  - nin[j] passes through a 2-FF synchroniser, then rising-edge detect.
  - On an edge: d_j = p - 2^(PHASE_W-1), signed, and vld_j = 1.
  - The first edge in a period wins; later edges in the same period are ignored.
  - All vld_j clear at the boundary. An edge coincident with the boundary belongs to the new period (vld set after clear).
- FSM:
  - IDLE -> ACCUM on a boundary when couple_en=1.
  - ACCUM: N_IN cycles, index j = 0..N_IN-1. sum += w_j*d_j if vld_j (snapshotted at the boundary), else +0.
  - sum width = PHASE_W + WEIGHT_W + clog2(N_IN), signed.
  - ACCUM -> APPLY; APPLY -> IDLE.
  - APPLY: corr = sum >>> SHIFT, truncated to PHASE_W. phi_reg <= phi_reg - corr (mod 2^PHASE_W). phi_out <= new phi_reg. phi_valid <= 1.
  - Latency: phi_valid rises N_IN+2 cycles after the boundary cycle.
  - A positive weight pulls toward in-phase: if own phase leads, d > 0 and phi decreases.
- Handshake: phi_valid clears on the cycle when phi_valid & phi_ready. If APPLY occurs while phi_valid is already set, phi_out is overwritten and phi_valid stays 1 (latest wins).
- Boundary while upd_busy=1: dropped; oscillator unaffected.
- phi_load has priority: phi_reg <= phi_init, FSM -> IDLE (update aborted, no phi_valid), and acc is unchanged.
- couple_en=0: captures continue, no update.

Optional Feature:
ONN_STEP_SAT_EN
- Defined: corr is clamped to [-MAX_STEP, +MAX_STEP] before subtraction.
- Undefined: corr is simply truncated to PHASE_W (wraps).

Decomposition:
- Package onn_pkg holds:
  - phase_t (PHASE_W logic)
  - weight_t (signed WEIGHT_W)
  - PHASE_HALF constant
  - FSM state enum IDLE/ACCUM/APPLY
- Sub-module onn_phase_capture: synchroniser, edge detect, d_j register and vld_j. Instantiated N_IN times.

Test Plan:
(bench uses PHASE_W=8, N_IN=4, SHIFT=1)
- Reset: hold reset=0 with toggling inputs -> nout=0, phi_out=0, phi_valid=0, upd_busy=0; after release with tick_en=1, nout is low for 128 cycles then high for 128.
- Single coupling: w0=+2, others 0; nin[0] rises when p=0xA0 -> d0=0x20, corr=0x20, phi 0x00 -> 0xE0; phi_valid at boundary+6 cycles; phi_ready=1 clears it next cycle.
- Sign/exclusion: w1=-1, nin[1] edge at p=0x70 (d=-0x10), nin[2] silent with w2=+7 -> sum=+0x10, corr=0x08, phi 0x00 -> 0xF8.
- Abort: phi_load=1 with phi_init=0x40 during ACCUM -> phi_reg=0x40, no phi_valid, FSM IDLE next cycle.
- Backpressure: phi_ready=0 across two updates -> phi_valid stays 1 and phi_out holds the second value.
- ONN_STEP_SAT_EN with MAX_STEP=0x10: the single-coupling case gives phi 0xF0 (0xE0 without the macro).
